// File: rtl/calc_input_sequencer_if.sv
// calc_input_sequencer_if
// Operand/handshake bundle between the input sequencer and the ALU that
// consumes its requests.
//   A, B      : latched operands
//   Opcode    : latched opcode
//   op_valid  : A/B/Opcode form a complete request
//   alu_ready : consumer accepts the operand set while high
// master = sequencer side, slave = ALU side.
interface calc_input_sequencer_if;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] Opcode;
    logic       op_valid;
    logic       alu_ready;

    modport master (
        output A,
        output B,
        output Opcode,
        output op_valid,
        input  alu_ready
    );

    modport slave (
        input  A,
        input  B,
        input  Opcode,
        input  op_valid,
        output alu_ready
    );
endinterface

// File: rtl/calc_input_sequencer.sv
// calc_input_sequencer
// Collects operand A, operand B and an opcode from a 4-bit switch bank using
// two raw pushbuttons (enter / back), then offers the complete request to an
// ALU with a valid/ready handshake.
// Ports:
//   fsmClk      : clock, all state updates on the rising edge
//   reset       : synchronous, active-high reset
//   sw          : raw switch value entered as A, B or Opcode
//   btn_enter   : raw asynchronous "accept" button
//   btn_back    : raw asynchronous "go back / cancel" button
//   alu         : master side of the operand/handshake bundle
//   stage       : current state encoding for display
//   entry_error : last opcode entry was rejected
//   issue_count : number of completed handshakes (wraps)
module calc_input_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                          fsmClk,
    input  logic                          reset,
    input  logic [3:0]                    sw,
    input  logic                          btn_enter,
    input  logic                          btn_back,
    calc_input_sequencer_if.master        alu,
    output logic [1:0]                    stage,
    output logic                          entry_error,
    output logic [7:0]                    issue_count
);

    typedef enum logic [1:0] {
        GET_A  = 2'd0,
        GET_B  = 2'd1,
        GET_OP = 2'd2,
        ISSUE  = 2'd3
    } state_t;

    localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_CYCLES - 1);

    // Index 0 = enter, index 1 = back.
    logic [1:0] btn_raw;
    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] deb;
    logic [1:0] deb_q;
    logic [3:0] db_cnt [2];
    logic [1:0] press;

    logic enter_ev;
    logic back_ev;

    state_t state;
    state_t state_nxt;

    logic [3:0] a_q;
    logic [3:0] b_q;
    logic [3:0] op_q;
    logic       valid_q;
    logic       err_q;
    logic [7:0] count_q;

    logic [3:0] a_nxt;
    logic [3:0] b_nxt;
    logic [3:0] op_nxt;
    logic       err_nxt;
    logic [7:0] count_nxt;

    logic op_illegal;
    logic handshake;

    assign btn_raw = {btn_back, btn_enter};

    // Two-flop synchronizer for both buttons.
    always_ff @(posedge fsmClk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Per-button debounce: the counter measures how long the synced level
    // has disagreed with the accepted level; any agreement restarts it.
    for (genvar i = 0; i < 2; i++) begin : g_debounce
        always_ff @(posedge fsmClk) begin
            if (reset) begin
                db_cnt[i] <= '0;
                deb[i]    <= 1'b0;
            end else if (sync2[i] != deb[i]) begin
                if (db_cnt[i] == DB_LAST) begin
                    deb[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 4'd1;
                end
            end else begin
                db_cnt[i] <= '0;
            end
        end
    end

    // Delayed copy of the debounced level; a press is its rising edge only.
    always_ff @(posedge fsmClk) begin
        if (reset) begin
            deb_q <= '0;
        end else begin
            deb_q <= deb;
        end
    end

    assign press    = deb & ~deb_q;
    assign enter_ev = press[0];
    assign back_ev  = press[1];

    // Opcodes above 4'b1100 do not exist; 4'b1001 is a divide and is
    // refused when the divisor B is zero.
    assign op_illegal = (sw > 4'b1100) || ((sw == 4'b1001) && (b_q == 4'd0));
    assign handshake  = (state == ISSUE) && alu.alu_ready;

    // State register.
    always_ff @(posedge fsmClk) begin
        if (reset) begin
            state <= GET_A;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. Back wins over enter while collecting; in ISSUE a
    // ready consumer wins over back.
    always_comb begin
        state_nxt = state;
        case (state)
            GET_A: begin
                if (!back_ev && enter_ev) begin
                    state_nxt = GET_B;
                end
            end
            GET_B: begin
                if (back_ev) begin
                    state_nxt = GET_A;
                end else if (enter_ev) begin
                    state_nxt = GET_OP;
                end
            end
            GET_OP: begin
                if (back_ev) begin
                    state_nxt = GET_B;
                end else if (enter_ev && !op_illegal) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (alu.alu_ready) begin
                    state_nxt = GET_A;
                end else if (back_ev) begin
                    state_nxt = GET_OP;
                end
            end
            default: state_nxt = GET_A;
        endcase
    end

    // Output logic: next values of the latched operands, error flag and
    // handshake counter.
    always_comb begin
        a_nxt     = a_q;
        b_nxt     = b_q;
        op_nxt    = op_q;
        err_nxt   = err_q;
        count_nxt = count_q;
        case (state)
            GET_A: begin
                if (!back_ev && enter_ev) begin
                    a_nxt = sw;
                end
            end
            GET_B: begin
                if (!back_ev && enter_ev) begin
                    b_nxt = sw;
                end
            end
            GET_OP: begin
                if (!back_ev && enter_ev) begin
                    if (op_illegal) begin
                        err_nxt = 1'b1;
                    end else begin
                        op_nxt  = sw;
                        err_nxt = 1'b0;
                    end
                end
            end
            ISSUE: begin
                if (handshake) begin
                    count_nxt = count_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    // Output registers; op_valid is registered from the next state so it
    // lines up exactly with stage == ISSUE.
    always_ff @(posedge fsmClk) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            err_q   <= 1'b0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            a_q     <= a_nxt;
            b_q     <= b_nxt;
            op_q    <= op_nxt;
            err_q   <= err_nxt;
            count_q <= count_nxt;
            valid_q <= (state_nxt == ISSUE);
        end
    end

    assign alu.A        = a_q;
    assign alu.B        = b_q;
    assign alu.Opcode   = op_q;
    assign alu.op_valid = valid_q;
    assign stage        = state;
    assign entry_error  = err_q;
    assign issue_count  = count_q;

endmodule
